dual_port_mem_arbiter: RTL and testbench
========================================

DUAL_PORT_MEM_ARBITER -- requirements
Module: dual_port_mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, address width of both requester ports and the memory port.
REQ-002 Parameter DATA_W, default 32, data width; byte-enable width is DATA_W/8.
REQ-003 clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_i  input  1  reset, synchronous and active-high.
REQ-005 pN_req_i  input  1  (N=0,1) request from requester N.
REQ-006 pN_gnt_o  output  1  grant to requester N; the request is accepted this cycle.
REQ-007 pN_rvalid_o  output  1  response valid for requester N.
REQ-008 pN_addr_i  input  ADDR_W  address; pN_we_i input 1 write enable; pN_be_i input DATA_W/8 byte enables; pN_wdata_i input DATA_W write data.
REQ-009 pN_rdata_o  output  DATA_W  read data, qualified by pN_rvalid_o.
REQ-010 mem_req_o  output  1  request to the shared memory.
REQ-011 mem_gnt_i  input  1  memory accepts mem_req_o this cycle.
REQ-012 mem_rvalid_i  input  1  memory response valid, in request order.
REQ-013 mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o  output  ADDR_W/1/DATA_W/8/DATA_W  request fields of the selected requester.
REQ-014 mem_rdata_i  input  DATA_W  memory read data.
REQ-015 protocol_err_o  output  1  sticky flag: response received with no outstanding request.

Function
REQ-016 The block SHALL keep a 2-entry in-order owner queue (one bit per entry) and a registered count of 0..2 outstanding requests.
REQ-017 mem_req_o SHALL be (p0_req_i | p1_req_i) & (count < 2), combinational, using the registered count.
REQ-018 Selection SHALL be: the sole requester if only one is requesting; otherwise the port named by the round-robin pointer prio.
REQ-019 mem_addr_o/we/be/wdata SHALL be driven combinationally from the selected port; when no request is present they SHALL carry port 0's fields.
REQ-020 pN_gnt_o SHALL be mem_req_o & mem_gnt_i & (selected == N); both grants SHALL never be high in the same cycle.
REQ-021 On a grant, the owner SHALL be pushed into the queue and prio SHALL be set to the other port at the next edge; with no grant, prio SHALL hold.
REQ-022 On mem_rvalid_i with count > 0, the head SHALL be popped and p<head>_rvalid_o SHALL be asserted in the same cycle; the other port's rvalid SHALL stay low.
REQ-023 Both pN_rdata_o SHALL equal mem_rdata_i at all times.
REQ-024 A push and a pop in the same cycle SHALL leave count unchanged and keep the queue order correct.
REQ-025 When count == 2, mem_req_o and both grants SHALL stay low, including in the cycle of a pop; requests resume the cycle after.
REQ-026 On mem_rvalid_i with count == 0, no pN_rvalid_o SHALL assert, the count SHALL stay at 0, and protocol_err_o SHALL be set until reset.
REQ-027 Requesters SHALL hold req and request fields stable until granted; the arbiter SHALL NOT register request fields, so grant latency is 0 cycles.

Reset
REQ-028 While rst_i is high at an edge: count=0, queue cleared, prio=0 and protocol_err_o=0; combinational outputs then follow REQ-017..023.
REQ-029 Reset mid-transaction SHALL discard all outstanding ownership; a later mem_rvalid_i SHALL set protocol_err_o per REQ-026.

Configuration
REQ-030 Macro MEM_ARB_PERF_EN: when defined, the following ports and logic SHALL exist: perf_clr_i input 1; perf_gnt0_o, perf_gnt1_o, perf_conflict_o outputs of 32 bits each.
REQ-031 With MEM_ARB_PERF_EN: perf_gntN_o SHALL increment on each pN_gnt_o, and perf_conflict_o SHALL increment each cycle in which both req_i are high and mem_req_o is high. Counters SHALL wrap at 2^32, reset to 0, and clear on perf_clr_i; clear SHALL win over a same-cycle increment.
REQ-032 Without MEM_ARB_PERF_EN: these ports and counters SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-033 p0 alone, mem_gnt_i=1, rvalid 1 cycle later, addr 0x100 -> p0_gnt_o in the same cycle, p0_rvalid_o next cycle, p1 signals quiet.
REQ-034 Both requesting continuously, mem_gnt_i=1, rvalid latency 1 -> grants alternate p0,p1,p0,p1; rvalids alternate in the same order one cycle later.
REQ-035 mem_gnt_i=1 for 3 cycles with rvalid held low -> only 2 grants, mem_req_o low on the 3rd cycle; one rvalid pulse -> a grant resumes the following cycle.
REQ-036 mem_rvalid_i pulse after reset with no request -> protocol_err_o=1 and stays 1; no pN_rvalid_o.
REQ-037 rst_i asserted with 1 outstanding request, then rvalid -> no pN_rvalid_o, protocol_err_o=1, prio=0 after reset.
REQ-038 (MEM_ARB_PERF_EN) 10 cycles with both ports requesting and always granted -> perf_gnt0=5, perf_gnt1=5, perf_conflict=10; perf_clr_i pulse -> all three are 0 the next cycle.

Source files
------------

// File: rtl/dual_port_mem_arbiter.sv
// rtl/dual_port_mem_arbiter.sv - round-robin arbiter sharing one in-order memory port between two requesters
//
// Purpose: picks one of two requesters per cycle (sole requester wins, otherwise the
// round-robin pointer decides), forwards its request fields combinationally to the
// memory port, and routes in-order memory responses back to the owner recorded in a
// 2-entry owner queue. At most two requests may be outstanding.
// Optional feature macro: MEM_ARB_PERF_EN adds grant/conflict performance counters.
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   pN_req_i / pN_gnt_o          request handshake for requester N (N=0,1)
//   pN_addr_i/we_i/be_i/wdata_i  request fields for requester N
//   pN_rvalid_o / pN_rdata_o     response to requester N
//   mem_req_o / mem_gnt_i        request handshake toward the memory
//   mem_addr_o/we_o/be_o/wdata_o request fields of the selected requester
//   mem_rvalid_i / mem_rdata_i   in-order memory response
//   protocol_err_o               sticky: response arrived with nothing outstanding
//   perf_clr_i, perf_gnt0_o, perf_gnt1_o, perf_conflict_o  (MEM_ARB_PERF_EN only)
module dual_port_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                p0_req_i,
  output logic                p0_gnt_o,
  output logic                p0_rvalid_o,
  input  logic [ADDR_W-1:0]   p0_addr_i,
  input  logic                p0_we_i,
  input  logic [DATA_W/8-1:0] p0_be_i,
  input  logic [DATA_W-1:0]   p0_wdata_i,
  output logic [DATA_W-1:0]   p0_rdata_o,
  input  logic                p1_req_i,
  output logic                p1_gnt_o,
  output logic                p1_rvalid_o,
  input  logic [ADDR_W-1:0]   p1_addr_i,
  input  logic                p1_we_i,
  input  logic [DATA_W/8-1:0] p1_be_i,
  input  logic [DATA_W-1:0]   p1_wdata_i,
  output logic [DATA_W-1:0]   p1_rdata_o,
  output logic                mem_req_o,
  input  logic                mem_gnt_i,
  input  logic                mem_rvalid_i,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic                mem_we_o,
  output logic [DATA_W/8-1:0] mem_be_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  input  logic [DATA_W-1:0]   mem_rdata_i,
  output logic                protocol_err_o
`ifdef MEM_ARB_PERF_EN
  ,
  input  logic                perf_clr_i,
  output logic [31:0]         perf_gnt0_o,
  output logic [31:0]         perf_gnt1_o,
  output logic [31:0]         perf_conflict_o
`endif
);

  logic [1:0] count_q, count_d;
  logic [1:0] owner_q, owner_d;   // bit 0 is the head (oldest outstanding owner)
  logic       prio_q, prio_d;
  logic       err_q, err_d;

  logic any_req, sel, push, pop, slot;

  always_comb begin
    any_req = p0_req_i | p1_req_i;
    if (p0_req_i && !p1_req_i)      sel = 1'b0;
    else if (p1_req_i && !p0_req_i) sel = 1'b1;
    else if (any_req)               sel = prio_q;
    else                            sel = 1'b0;

    mem_req_o   = any_req & (count_q != 2'd2);
    mem_addr_o  = sel ? p1_addr_i  : p0_addr_i;
    mem_we_o    = sel ? p1_we_i    : p0_we_i;
    mem_be_o    = sel ? p1_be_i    : p0_be_i;
    mem_wdata_o = sel ? p1_wdata_i : p0_wdata_i;

    push     = mem_req_o & mem_gnt_i;
    p0_gnt_o = push & ~sel;
    p1_gnt_o = push & sel;

    pop         = mem_rvalid_i & (count_q != 2'd0);
    p0_rvalid_o = pop & ~owner_q[0];
    p1_rvalid_o = pop & owner_q[0];
    p0_rdata_o  = mem_rdata_i;
    p1_rdata_o  = mem_rdata_i;

    // Shift out the head first, then write the new owner into the first free slot.
    // A push only happens with count 0 or 1, so the free slot after the pop is
    // count[0] with no pop, and slot 0 when a pop frees the single occupied entry.
    owner_d = owner_q;
    if (pop) owner_d = {1'b0, owner_q[1]};
    slot = count_q[0] ^ pop;
    if (push) owner_d[slot] = sel;

    count_d = count_q - {1'b0, pop} + {1'b0, push};
    prio_d  = push ? ~sel : prio_q;
    err_d   = err_q | (mem_rvalid_i & (count_q == 2'd0));

    protocol_err_o = err_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= 2'd0;
      owner_q <= 2'b00;
      prio_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      owner_q <= owner_d;
      prio_q  <= prio_d;
      err_q   <= err_d;
    end
  end

`ifdef MEM_ARB_PERF_EN
  logic [31:0] perf_gnt0_q, perf_gnt0_d;
  logic [31:0] perf_gnt1_q, perf_gnt1_d;
  logic [31:0] perf_conflict_q, perf_conflict_d;

  // Clear takes precedence over any increment in the same cycle; counters wrap.
  always_comb begin
    perf_gnt0_d     = perf_clr_i ? 32'd0 : perf_gnt0_q + {31'd0, p0_gnt_o};
    perf_gnt1_d     = perf_clr_i ? 32'd0 : perf_gnt1_q + {31'd0, p1_gnt_o};
    perf_conflict_d = perf_clr_i ? 32'd0
                    : perf_conflict_q + {31'd0, p0_req_i & p1_req_i & mem_req_o};
    perf_gnt0_o     = perf_gnt0_q;
    perf_gnt1_o     = perf_gnt1_q;
    perf_conflict_o = perf_conflict_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_gnt0_q     <= 32'd0;
      perf_gnt1_q     <= 32'd0;
      perf_conflict_q <= 32'd0;
    end else begin
      perf_gnt0_q     <= perf_gnt0_d;
      perf_gnt1_q     <= perf_gnt1_d;
      perf_conflict_q <= perf_conflict_d;
    end
  end
`endif

endmodule

// File: tb/tb_dual_port_mem_arbiter.sv
// tb/tb_dual_port_mem_arbiter.sv - scoreboard bench for dual_port_mem_arbiter
module tb_dual_port_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          p0_req, p1_req, p0_we, p1_we;
  logic [AW-1:0] p0_addr, p1_addr;
  logic [BW-1:0] p0_be, p1_be;
  logic [DW-1:0] p0_wdata, p1_wdata;
  logic          p0_gnt_o, p1_gnt_o, p0_rvalid_o, p1_rvalid_o;
  logic [DW-1:0] p0_rdata_o, p1_rdata_o;
  logic          mem_req_o, mem_gnt, mem_rvalid, mem_we_o, protocol_err_o;
  logic [AW-1:0] mem_addr_o;
  logic [BW-1:0] mem_be_o;
  logic [DW-1:0] mem_wdata_o, mem_rdata;
`ifdef MEM_ARB_PERF_EN
  logic          perf_clr;
  logic [31:0]   perf_gnt0, perf_gnt1, perf_conflict;
`endif

  dual_port_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk_i(clk), .rst_i(rst),
    .p0_req_i(p0_req), .p0_gnt_o(p0_gnt_o), .p0_rvalid_o(p0_rvalid_o),
    .p0_addr_i(p0_addr), .p0_we_i(p0_we), .p0_be_i(p0_be), .p0_wdata_i(p0_wdata),
    .p0_rdata_o(p0_rdata_o),
    .p1_req_i(p1_req), .p1_gnt_o(p1_gnt_o), .p1_rvalid_o(p1_rvalid_o),
    .p1_addr_i(p1_addr), .p1_we_i(p1_we), .p1_be_i(p1_be), .p1_wdata_i(p1_wdata),
    .p1_rdata_o(p1_rdata_o),
    .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid),
    .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata),
    .protocol_err_o(protocol_err_o)
`ifdef MEM_ARB_PERF_EN
    ,
    .perf_clr_i(perf_clr), .perf_gnt0_o(perf_gnt0), .perf_gnt1_o(perf_gnt1),
    .perf_conflict_o(perf_conflict)
`endif
  );

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model: owners of accepted requests in order, round-robin pointer,
  // sticky error; memory emulator's pending response data; response scoreboard.
  int            own_q[$];
  logic [DW-1:0] pend_q[$];
  int            sb_port[$];
  logic [DW-1:0] sb_data[$];
  int            prio_m;
  bit            err_m;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every response the DUT presents is matched against the scoreboard.
  int            mon_port;
  logic [DW-1:0] mon_data;
  always @(negedge clk) begin
    if (!rst && (p0_rvalid_o || p1_rvalid_o)) begin
      if (sb_port.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_rvalid: got p0=%0b p1=%0b expected none at %0t",
                 p0_rvalid_o, p1_rvalid_o, $time);
      end else begin
        mon_port = sb_port.pop_front();
        mon_data = sb_data.pop_front();
        check("rsp_port", {63'd0, p1_rvalid_o}, 64'(mon_port));
        check("rsp_data", 64'(p1_rvalid_o ? p1_rdata_o : p0_rdata_o), 64'(mon_data));
      end
    end
  end

  // One clock cycle: drive inputs, check combinational outputs, advance the model.
  task automatic cycle(input bit r0, input bit r1, input bit g, input bit rv);
    int            sel;
    int            head;
    bit            ereq;
    bit            popped;
    logic [DW-1:0] rd;
    @(posedge clk);
    #1;
    p0_req = r0;            p1_req = r1;
    p0_addr = $urandom;     p1_addr = $urandom;
    p0_we = 1'($urandom);   p1_we = 1'($urandom);
    p0_be = 4'($urandom);   p1_be = 4'($urandom);
    p0_wdata = $urandom;    p1_wdata = $urandom;
    mem_gnt = g;
    mem_rvalid = rv;
    if (rv && pend_q.size() > 0) rd = pend_q.pop_front();
    else rd = $urandom;
    mem_rdata = rd;
    popped = rv && (own_q.size() > 0);
    head = popped ? own_q[0] : 0;
    ereq = (r0 || r1) && (own_q.size() < 2);
    sel = (r0 && !r1) ? 0 : (r1 && !r0) ? 1 : (r0 && r1) ? prio_m : 0;
    #2;
    check("mem_req", 64'(mem_req_o), 64'(ereq));
    check("p0_gnt", 64'(p0_gnt_o), 64'(ereq && g && sel == 0));
    check("p1_gnt", 64'(p1_gnt_o), 64'(ereq && g && sel == 1));
    check("p0_rvalid", 64'(p0_rvalid_o), 64'(popped && head == 0));
    check("p1_rvalid", 64'(p1_rvalid_o), 64'(popped && head == 1));
    check("mem_addr", 64'(mem_addr_o), 64'(sel == 1 ? p1_addr : p0_addr));
    check("mem_we", 64'(mem_we_o), 64'(sel == 1 ? p1_we : p0_we));
    check("mem_be", 64'(mem_be_o), 64'(sel == 1 ? p1_be : p0_be));
    check("mem_wdata", 64'(mem_wdata_o), 64'(sel == 1 ? p1_wdata : p0_wdata));
    check("p0_rdata", 64'(p0_rdata_o), 64'(rd));
    check("p1_rdata", 64'(p1_rdata_o), 64'(rd));
    check("protocol_err", 64'(protocol_err_o), 64'(err_m));
    if (rv) begin
      if (own_q.size() > 0) void'(own_q.pop_front());
      else err_m = 1'b1;
    end
    if (ereq && g) begin
      own_q.push_back(sel);
      prio_m = 1 - sel;
      rd = $urandom;
      pend_q.push_back(rd);
      sb_port.push_back(sel);
      sb_data.push_back(rd);
    end
  endtask

  task automatic do_reset(input bit keep_pend);
    @(posedge clk);
    #1;
    rst = 1'b1;
    p0_req = 1'b0; p1_req = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    own_q.delete();
    sb_port.delete();
    sb_data.delete();
    prio_m = 0;
    err_m = 1'b0;
    if (!keep_pend) pend_q.delete();
  endtask

  task automatic drain();
    for (int k = 0; k < 8 && pend_q.size() > 0; k++) cycle(1'b0, 1'b0, 1'b0, 1'b1);
    check("drained", 64'(pend_q.size()), 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    p0_req = 0; p1_req = 0; p0_we = 0; p1_we = 0; p0_addr = 0; p1_addr = 0;
    p0_be = 0; p1_be = 0; p0_wdata = 0; p1_wdata = 0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
    prio_m = 0; err_m = 1'b0;
`ifdef MEM_ARB_PERF_EN
    perf_clr = 1'b0;
`endif
    do_reset(1'b0);

    // Idle after reset, then a single p0 transaction with 1-cycle response.
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);

    // Both requesting continuously with 1-cycle latency: grants alternate.
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b1, 1'b1, pend_q.size() > 0);
    drain();

    // Fill both slots, third cycle blocked, pop cycle still blocked, then resume.
    cycle(1'b1, 1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 1'b1);
    cycle(1'b1, 1'b1, 1'b1, 1'b0);
    drain();

    // Randomized traffic.
    for (int i = 0; i < 2000; i++)
      cycle(1'($urandom), 1'($urandom), 1'($urandom),
            (pend_q.size() > 0) && ($urandom_range(0, 2) != 0));
    drain();

    // Response with nothing outstanding sets a sticky error.
    do_reset(1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 1'b0);
    drain();

    // Reset with one outstanding p0 request: stale response errors, prio back to p0.
    do_reset(1'b0);
    cycle(1'b1, 1'b0, 1'b1, 1'b0);
    do_reset(1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 1'b1, 1'b0);
    drain();

`ifdef MEM_ARB_PERF_EN
    do_reset(1'b0);
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1, 1'b1, pend_q.size() > 0);
    cycle(1'b0, 1'b0, 1'b0, pend_q.size() > 0);
    check("perf_gnt0", 64'(perf_gnt0), 64'd5);
    check("perf_gnt1", 64'(perf_gnt1), 64'd5);
    check("perf_conflict", 64'(perf_conflict), 64'd10);
    perf_clr = 1'b1;
    cycle(1'b1, 1'b1, 1'b1, 1'b0);
    perf_clr = 1'b0;
    check("perf_gnt0_clr", 64'(perf_gnt0), 64'd0);
    check("perf_gnt1_clr", 64'(perf_gnt1), 64'd0);
    check("perf_conflict_clr", 64'(perf_conflict), 64'd0);
    drain();
`endif

    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    check("scoreboard_empty", 64'(sb_port.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
